dcache_clr_ctrl: RTL



---
 rtl/dcache_clr_ctrl_pkg.sv | 29 ++
 rtl/dcache_clr_ctrl.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/dcache_clr_ctrl_pkg.sv
// Shared types and helpers for the dcache tag-store clear controller.
package dcache_clr_ctrl_pkg;

    // Command opcodes as presented by the CSR unit
    typedef enum logic [1:0] {
        CLR_OP_ALL   = 2'b00,
        CLR_OP_LINE  = 2'b01,
        CLR_OP_RANGE = 2'b10,
        CLR_OP_RSV   = 2'b11
    } dcache_clr_op_e;

    // Controller states
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WAIT     = 3'd1,
        ST_CLR_ALL  = 3'd2,
        ST_CLR_LINE = 3'd3,
        ST_DONE     = 3'd4
    } dcache_clr_state_e;

    // Bytes per cache line for a given log2(words per line)
    function automatic int unsigned line_bytes(input int unsigned word_sel);
        return 32'd1 << (word_sel + 32'd2);
    endfunction

    // Line size of the default configuration (16 words of 4 bytes)
    localparam int unsigned LINE_BYTES_DEF = 64;

endpackage

// File: rtl/dcache_clr_ctrl.sv
// CSR-side initiator for dcache tag-store invalidation.
// Accepts all/line/range invalidate commands, waits for the cache pipeline
// to go idle, and emits clear_all / clear_line strobes broadcast to every way.
//
// state       | meaning
// ------------+-------------------------------------------------------------
// ST_IDLE     | ready for a command
// ST_WAIT     | command captured, waiting for the pipeline to drain
// ST_CLR_ALL  | clear_all_o strobe is on the wire this cycle
// ST_CLR_LINE | walking lines; strobes issued whenever the pipeline is idle
// ST_DONE     | done_o (and err_o for a reserved op) pulse this cycle
module dcache_clr_ctrl
    import dcache_clr_ctrl_pkg::*;
#(
    parameter int unsigned AWT       = 32,
    parameter int unsigned WORD_SEL  = 4,
    parameter int unsigned ENTRY_SEL = 7,
    parameter int unsigned LEN_WT    = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cmd_vld_i,
    output logic              cmd_rdy_o,
    input  logic [1:0]        cmd_op_i,
    input  logic [AWT-1:0]    cmd_addr_i,
    input  logic [LEN_WT-1:0] cmd_len_i,
    input  logic              pipe_idle_i,
    output logic              clear_all_o,
    output logic              clear_line_o,
    output logic [AWT-1:0]    clear_addr_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o
);

    localparam int unsigned       ENTRY_NUM = 1 << ENTRY_SEL;
    localparam logic [AWT-1:0]    LINE_INC  = AWT'(line_bytes(WORD_SEL));
    localparam logic [AWT-1:0]    OFS_MASK  = LINE_INC - AWT'(1);
    localparam logic [LEN_WT-1:0] LEN_ALL   = LEN_WT'(ENTRY_NUM);

    dcache_clr_state_e r_state;
    logic              r_cmd_rdy;
    logic              r_clear_all;
    logic              r_clear_line;
    logic [AWT-1:0]    r_clear_addr;
    logic              r_busy;
    logic              r_done;
    logic              r_err;
    logic              r_all;
    logic [AWT-1:0]    r_addr;
    logic [LEN_WT-1:0] r_cnt;

    dcache_clr_op_e    w_op;
    logic              w_accept;
    logic              w_is_all;
    logic              w_is_nop;
    logic              w_is_rsv;
    logic [LEN_WT-1:0] w_len_norm;
    logic [AWT-1:0]    w_addr_aligned;
    logic              w_issue;

    assign w_op           = dcache_clr_op_e'(cmd_op_i);
    assign w_accept       = cmd_vld_i & r_cmd_rdy;
    assign w_addr_aligned = cmd_addr_i & ~OFS_MASK;

    // Fold the four opcodes into "whole cache", "N lines", "nothing" or "reserved"
    always_comb begin
        w_is_all   = 1'b0;
        w_is_nop   = 1'b0;
        w_is_rsv   = 1'b0;
        w_len_norm = '0;
        case (w_op)
            CLR_OP_ALL: begin
                w_is_all = 1'b1;
            end
            CLR_OP_LINE: begin
                w_len_norm = LEN_WT'(1);
            end
            CLR_OP_RANGE: begin
                if (cmd_len_i == '0) begin
                    w_is_nop = 1'b1;
                end else if (cmd_len_i >= LEN_ALL) begin
                    // Covering every set is cheaper as a single clear-all
                    w_is_all = 1'b1;
                end else begin
                    w_len_norm = cmd_len_i;
                end
            end
            default: begin
                w_is_rsv = 1'b1;
            end
        endcase
    end

    // A line strobe goes out on every pipeline-idle edge while lines remain;
    // the first one is launched straight from WAIT so it lands at accept+2.
    assign w_issue = pipe_idle_i &
                     (((r_state == ST_WAIT) & ~r_all) |
                      ((r_state == ST_CLR_LINE) & (r_cnt != '0)));

    // Controller FSM with registered handshake, strobe and status outputs
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state      <= ST_IDLE;
            r_cmd_rdy    <= 1'b1;
            r_clear_all  <= 1'b0;
            r_clear_line <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_all        <= 1'b0;
        end else begin
            r_clear_all  <= 1'b0;
            r_clear_line <= w_issue;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_cmd_rdy <= 1'b0;
                        r_busy    <= 1'b1;
                        r_all     <= w_is_all;
                        if (w_is_rsv || w_is_nop) begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                            r_err   <= w_is_rsv;
                        end else begin
                            r_state <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (pipe_idle_i) begin
                        if (r_all) begin
                            r_state     <= ST_CLR_ALL;
                            r_clear_all <= 1'b1;
                        end else begin
                            r_state <= ST_CLR_LINE;
                        end
                    end
                end
                ST_CLR_ALL: begin
                    r_state <= ST_DONE;
                    r_done  <= 1'b1;
                end
                ST_CLR_LINE: begin
                    // Count reaching zero means the last strobe is on the wire now
                    if (r_cnt == '0) begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    r_state   <= ST_IDLE;
                    r_cmd_rdy <= 1'b1;
                    r_busy    <= 1'b0;
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_cmd_rdy <= 1'b1;
                    r_busy    <= 1'b0;
                end
            endcase
        end
    end

    // Line address walker: load on accept, present and advance on each strobe
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_addr       <= '0;
            r_cnt        <= '0;
            r_clear_addr <= '0;
        end else if (w_accept) begin
            r_addr <= w_addr_aligned;
            r_cnt  <= w_len_norm;
        end else if (w_issue) begin
            r_clear_addr <= r_addr;
            r_addr       <= r_addr + LINE_INC;
            r_cnt        <= r_cnt - LEN_WT'(1);
        end
    end

    assign cmd_rdy_o    = r_cmd_rdy;
    assign clear_all_o  = r_clear_all;
    assign clear_line_o = r_clear_line;
    assign clear_addr_o = r_clear_addr;
    assign busy_o       = r_busy;
    assign done_o       = r_done;
    assign err_o        = r_err;

endmodule
